// File: rtl/frame_swap_scheduler.sv
// Double-buffered frame store sequencer: clear, draw, wait for VSYNC, swap.
// Ports: clk/rst, vsync, draw_* renderer port, fb_* back-buffer write port,
//   draw_grant, front_sel, frame_start, missed_frames.
module frame_swap_scheduler #(
  parameter int              ADDR_W      = 15,
  parameter int              DATA_W      = 8,
  parameter int              NUM_PIXELS  = 19200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_data,
  input  logic              draw_done,
  output logic              draw_grant,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              front_sel,
  output logic              frame_start,
  output logic [7:0]        missed_frames
);

  typedef enum logic [1:0] {
    CLEAR,
    DRAW,
    WAIT_VSYNC,
    SWAP
  } state_t;

  localparam int LAST_I = NUM_PIXELS - 1;
  localparam logic [ADDR_W-1:0] LAST = LAST_I[ADDR_W-1:0];
  localparam logic [ADDR_W:0] NPIX = NUM_PIXELS[ADDR_W:0];

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              vsync_last;
  logic              vedge;
  logic              in_range;
  logic              miss_inc;
  logic              swap_q, swap_n;
  logic [7:0]        missed_n;
  logic              front_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;
  logic              grant_n;

  assign vedge    = vsync & ~vsync_last;
  assign in_range = {1'b0, draw_addr} < NPIX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CLEAR;
      cnt           <= '0;
      vsync_last    <= 1'b1;
      swap_q        <= 1'b0;
      front_sel     <= 1'b0;
      frame_start   <= 1'b0;
      missed_frames <= '0;
      draw_grant    <= 1'b0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      fb_data       <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      vsync_last    <= vsync;
      swap_q        <= swap_n;
      front_sel     <= front_n;
      frame_start   <= swap_q;
      missed_frames <= missed_n;
      draw_grant    <= grant_n;
      fb_we         <= we_n;
      fb_addr       <= addr_n;
      fb_data       <= data_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    front_n  = front_sel;
    swap_n   = 1'b0;
    miss_inc = 1'b0;
    we_n     = 1'b0;
    addr_n   = fb_addr;
    data_n   = fb_data;
    grant_n  = 1'b0;
    unique case (state)
      CLEAR: begin
        we_n   = 1'b1;
        addr_n = cnt;
        data_n = CLEAR_COLOR;
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = DRAW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
        miss_inc = vedge;
      end
      DRAW: begin
        grant_n = 1'b1;
        // Renderer strobes only count once it has actually seen the grant.
        if (draw_grant) begin
          we_n   = draw_we & in_range;
          addr_n = draw_addr;
          data_n = draw_data;
        end
        if (draw_done && vedge) begin
          state_n = SWAP;
        end else if (draw_done) begin
          state_n = WAIT_VSYNC;
        end else begin
          miss_inc = vedge;
        end
      end
      WAIT_VSYNC: begin
        if (vedge) begin
          state_n = SWAP;
        end
      end
      SWAP: begin
        front_n = ~front_sel;
        swap_n  = 1'b1;
        state_n = CLEAR;
      end
    endcase
    missed_n = missed_frames;
    if (miss_inc && (missed_frames != 8'hFF)) begin
      missed_n = missed_frames + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Bench for frame_swap_scheduler with a 16-pixel frame.
// Vector table for renderer writes plus scoreboarded multi-cycle sequences.
module tb_frame_swap_scheduler;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          draw_we;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_data;
  logic          draw_done;
  logic          draw_grant;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;
  logic          front_sel;
  logic          frame_start;
  logic [7:0]    missed_frames;

  frame_swap_scheduler #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .NUM_PIXELS(NP),
    .CLEAR_COLOR(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vsync(vsync),
    .draw_we(draw_we),
    .draw_addr(draw_addr),
    .draw_data(draw_data),
    .draw_done(draw_done),
    .draw_grant(draw_grant),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .front_sel(front_sel),
    .frame_start(frame_start),
    .missed_frames(missed_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          grant;
    logic          front;
    logic          fs;
    logic [7:0]    missed;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_we;
  } vec_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input exp_t e);
    bit ok;
    checks++;
    ok = (fb_we === e.we) && (draw_grant === e.grant) &&
         (front_sel === e.front) && (frame_start === e.fs) &&
         (missed_frames === e.missed);
    if (e.we)
      ok = ok && (fb_addr === e.addr) && (fb_data === e.data);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got we=%b addr=%0d data=%h grant=%b front=%b fs=%b missed=%0d want we=%b addr=%0d data=%h grant=%b front=%b fs=%b missed=%0d",
               e.name, fb_we, fb_addr, fb_data, draw_grant, front_sel,
               frame_start, missed_frames, e.we, e.addr, e.data, e.grant,
               e.front, e.fs, e.missed);
    end
  endtask

  function automatic exp_t mk(input string n, input logic we,
                              input int addr, input logic [DW-1:0] data,
                              input logic grant, input logic front,
                              input logic fs, input int missed);
    exp_t e;
    e.name   = n;
    e.we     = we;
    e.addr   = addr[AW-1:0];
    e.data   = data;
    e.grant  = grant;
    e.front  = front;
    e.fs     = fs;
    e.missed = missed[7:0];
    return e;
  endfunction

  // One clock; compare whatever was expected for this edge.
  task automatic step();
    @(posedge clk);
    #1;
    while (q.size() > 0) cmp(q.pop_front());
  endtask

  // Full clear pass followed by the grant-rise cycle.
  task automatic run_clear(input logic front, input logic fs_first,
                           input int missed);
    for (int i = 0; i < NP; i++) begin
      q.push_back(mk($sformatf("clear%0d", i), 1'b1, i, 8'h00, 1'b0,
                     front, (i == 0) ? fs_first : 1'b0, missed));
      step();
    end
    q.push_back(mk("grant_rise", 1'b0, 0, 8'h00, 1'b1, front, 1'b0,
                   missed));
    step();
  endtask

  vec_t vt[6];

  initial begin
    int m;
    vt[0] = '{1'b1, 15'd5,     8'hE3, 1'b1};
    vt[1] = '{1'b1, 15'd16,    8'hAA, 1'b0};
    vt[2] = '{1'b0, 15'd7,     8'h11, 1'b0};
    vt[3] = '{1'b1, 15'd15,    8'h5C, 1'b1};
    vt[4] = '{1'b1, 15'd0,     8'hFF, 1'b1};
    vt[5] = '{1'b1, 15'd32767, 8'h12, 1'b0};

    rst       = 1'b1;
    vsync     = 1'b1;
    draw_we   = 1'b0;
    draw_addr = '0;
    draw_data = '0;
    draw_done = 1'b0;
    @(posedge clk);
    #1;
    cmp(mk("reset", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0));
    rst = 1'b0;

    run_clear(1'b0, 1'b0, 0);

    foreach (vt[i]) begin
      draw_we   = vt[i].we;
      draw_addr = vt[i].addr;
      draw_data = vt[i].data;
      q.push_back(mk($sformatf("vec%0d", i), vt[i].exp_we, vt[i].addr,
                     vt[i].data, 1'b1, 1'b0, 1'b0, 0));
      step();
    end
    draw_we = 1'b0;

    draw_done = 1'b1;
    vsync     = 1'b0;
    q.push_back(mk("done_edge", 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0));
    step();
    draw_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      q.push_back(mk("wait", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0));
      step();
    end
    vsync = 1'b1;
    q.push_back(mk("vedge_wait", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0));
    step();
    q.push_back(mk("swap_front", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0));
    step();
    run_clear(1'b1, 1'b1, 0);

    for (int n = 1; n <= 256; n++) begin
      m = (n - 1 > 255) ? 255 : n - 1;
      vsync = 1'b0;
      q.push_back(mk("miss_low", 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, m));
      step();
      m = (n > 255) ? 255 : n;
      vsync = 1'b1;
      q.push_back(mk($sformatf("miss%0d", n), 1'b0, 0, 0, 1'b1, 1'b1,
                     1'b0, m));
      step();
    end

    vsync = 1'b0;
    q.push_back(mk("sim_low", 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 255));
    step();
    vsync     = 1'b1;
    draw_done = 1'b1;
    q.push_back(mk("sim_edge", 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 255));
    step();
    draw_done = 1'b0;
    q.push_back(mk("sim_swap", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 255));
    step();
    run_clear(1'b0, 1'b1, 255);

    vsync     = 1'b0;
    draw_done = 1'b1;
    q.push_back(mk("d2_done", 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 255));
    step();
    draw_done = 1'b0;
    q.push_back(mk("d2_wait", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 255));
    step();
    vsync = 1'b1;
    q.push_back(mk("d2_edge", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 255));
    step();
    q.push_back(mk("d2_swap", 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 255));
    step();
    run_clear(1'b1, 1'b1, 255);

    draw_we   = 1'b1;
    draw_addr = 15'd9;
    draw_data = 8'h3C;
    q.push_back(mk("pre_rst_wr", 1'b1, 9, 8'h3C, 1'b1, 1'b1, 1'b0, 255));
    step();
    rst = 1'b1;
    #1;
    cmp(mk("async_rst", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0));
    draw_addr = 15'd3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_clear(1'b0, 1'b0, 0);
    q.push_back(mk("post_rst_wr", 1'b1, 3, 8'h3C, 1'b1, 1'b0, 1'b0, 0));
    step();
    draw_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
